rob: RTL

Reorder buffer for the out-of-order core: a circular queue of in-flight instructions, allocated in program order at issue and retired in program order.
- Sits downstream of the reservation stations and load/store buffer; captures their results from the common data bus (CDB).
- Answers the decoder's operand-dependency queries.
- Commits one instruction per cycle to the register file or load/store buffer.
- Raises a pipeline flush on branch mispredict.

---
 rtl/rob.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/rob.sv
// rob: reorder buffer for the out-of-order core.
//   Circular queue of in-flight instructions: allocated in program order at
//   issue, completed out of order from the CDB, retired in order one per
//   cycle. A mispredicted branch at the head raises a flush and empties the
//   buffer.
//
// Ports
//   clk_in, rst_in (async, active-low), rdy_in (low pauses the block)
//   rob_full, rob_tail_id, rob_head_id          occupancy / pointers
//   inst_input, inst_type, inst_rd,
//   inst_pred_jump                              issue from decoder
//   q1_id/q2_id -> q*_ready, q*_value           operand queries (with CDB bypass)
//   cdb_valid, cdb_rob_id, cdb_value, cdb_jump  result broadcast
//   commit_reg, commit_rd, commit_value,
//   commit_rob_id, commit_store                 registered retire outputs
//   flush, flush_pc                             registered mispredict redirect
module rob #(
  parameter int ROB_SIZE_BIT = 3
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  output logic                    rob_full,
  output logic [ROB_SIZE_BIT-1:0] rob_tail_id,
  output logic [ROB_SIZE_BIT-1:0] rob_head_id,
  input  logic                    inst_input,
  input  logic [1:0]              inst_type,
  input  logic [4:0]              inst_rd,
  input  logic                    inst_pred_jump,
  input  logic [ROB_SIZE_BIT-1:0] q1_id,
  input  logic [ROB_SIZE_BIT-1:0] q2_id,
  output logic                    q1_ready,
  output logic                    q2_ready,
  output logic [31:0]             q1_value,
  output logic [31:0]             q2_value,
  input  logic                    cdb_valid,
  input  logic [ROB_SIZE_BIT-1:0] cdb_rob_id,
  input  logic [31:0]             cdb_value,
  input  logic                    cdb_jump,
  output logic                    commit_reg,
  output logic [4:0]              commit_rd,
  output logic [31:0]             commit_value,
  output logic [ROB_SIZE_BIT-1:0] commit_rob_id,
  output logic                    commit_store,
  output logic                    flush,
  output logic [31:0]             flush_pc
);

  localparam int DEPTH = 1 << ROB_SIZE_BIT;
  localparam logic [ROB_SIZE_BIT:0] FULL_CNT = (ROB_SIZE_BIT+1)'(DEPTH);

  typedef enum logic [1:0] {
    T_REG    = 2'd0,
    T_BRANCH = 2'd1,
    T_STORE  = 2'd2,
    T_RSV    = 2'd3
  } inst_type_e;

  logic [DEPTH-1:0]        r_busy;
  logic [DEPTH-1:0]        r_ready;
  logic [DEPTH-1:0]        r_pred;
  logic [DEPTH-1:0]        r_jump;
  inst_type_e              r_type  [DEPTH];
  logic [4:0]              r_rd    [DEPTH];
  logic [31:0]             r_value [DEPTH];

  logic [ROB_SIZE_BIT-1:0] r_head;
  logic [ROB_SIZE_BIT-1:0] r_tail;
  logic [ROB_SIZE_BIT:0]   r_count;

  logic                    r_commit_reg;
  logic [4:0]              r_commit_rd;
  logic [31:0]             r_commit_value;
  logic [ROB_SIZE_BIT-1:0] r_commit_rob_id;
  logic                    r_commit_store;
  logic                    r_flush;
  logic [31:0]             r_flush_pc;

  logic w_full;
  logic w_commit;
  logic w_mispred;
  logic w_issue;
  logic w_capture;

  assign w_full    = (r_count == FULL_CNT);
  assign w_commit  = rdy_in && r_busy[r_head] && r_ready[r_head];
  assign w_mispred = w_commit && (r_type[r_head] == T_BRANCH) &&
                     (r_jump[r_head] != r_pred[r_head]);
  // Issue uses the registered count, so a commit in the same cycle never
  // makes room for an issue while full. A flushing cycle drops the issue.
  assign w_issue   = rdy_in && inst_input && !w_full && !w_mispred;
  assign w_capture = rdy_in && cdb_valid && r_busy[cdb_rob_id];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_busy          <= '0;
      r_ready         <= '0;
      r_pred          <= '0;
      r_jump          <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_type[i]  <= T_REG;
        r_rd[i]    <= '0;
        r_value[i] <= '0;
      end
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_commit_reg    <= 1'b0;
      r_commit_rd     <= '0;
      r_commit_value  <= '0;
      r_commit_rob_id <= '0;
      r_commit_store  <= 1'b0;
      r_flush         <= 1'b0;
      r_flush_pc      <= '0;
    end else begin
      r_commit_reg   <= 1'b0;
      r_commit_store <= 1'b0;
      r_flush        <= 1'b0;

      if (w_mispred) begin
        r_busy     <= '0;
        r_ready    <= '0;
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_flush    <= 1'b1;
        r_flush_pc <= r_value[r_head];
      end else begin
        if (w_commit) begin
          r_busy[r_head]  <= 1'b0;
          r_ready[r_head] <= 1'b0;
          r_head          <= r_head + 1'b1;
          case (r_type[r_head])
            T_REG, T_RSV: begin
              r_commit_reg    <= 1'b1;
              // Reserved type retires like REG but never names a register.
              r_commit_rd     <= (r_type[r_head] == T_REG) ? r_rd[r_head] : 5'd0;
              r_commit_value  <= r_value[r_head];
              r_commit_rob_id <= r_head;
            end
            T_STORE: begin
              r_commit_store  <= 1'b1;
              r_commit_rob_id <= r_head;
            end
            default: ;
          endcase
        end

        if (w_capture) begin
          r_ready[cdb_rob_id] <= 1'b1;
          r_value[cdb_rob_id] <= cdb_value;
          r_jump[cdb_rob_id]  <= cdb_jump;
        end

        // The tail slot is never busy when issue is allowed, so this cannot
        // collide with the capture or commit above.
        if (w_issue) begin
          r_busy[r_tail]  <= 1'b1;
          r_ready[r_tail] <= 1'b0;
          r_type[r_tail]  <= inst_type_e'(inst_type);
          r_rd[r_tail]    <= inst_rd;
          r_pred[r_tail]  <= inst_pred_jump;
          r_tail          <= r_tail + 1'b1;
        end

        case ({w_issue, w_commit})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign rob_full    = w_full;
  assign rob_tail_id = r_tail;
  assign rob_head_id = r_head;

  // Same-cycle CDB bypass so the decoder sees a result as it is broadcast.
  always_comb begin
    q1_ready = r_ready[q1_id];
    q1_value = r_value[q1_id];
    q2_ready = r_ready[q2_id];
    q2_value = r_value[q2_id];
    if (cdb_valid && (cdb_rob_id == q1_id)) begin
      q1_ready = 1'b1;
      q1_value = cdb_value;
    end
    if (cdb_valid && (cdb_rob_id == q2_id)) begin
      q2_ready = 1'b1;
      q2_value = cdb_value;
    end
  end

  assign commit_reg    = r_commit_reg;
  assign commit_rd     = r_commit_rd;
  assign commit_value  = r_commit_value;
  assign commit_rob_id = r_commit_rob_id;
  assign commit_store  = r_commit_store;
  assign flush         = r_flush;
  assign flush_pc      = r_flush_pc;

endmodule
